// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the host link and the program loader.
interface imem_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory: count, 3 bytes per word, XOR checksum.
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int IW    = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bs,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [IW-1:0] wr_data,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);
    typedef enum logic [2:0] {IDLE, COUNT, B0, B1, B2, WRITE, CHECK, FINISH} state_t;

    state_t        state, state_n;
    logic [AW:0]   cnt, n;
    logic [IW-1:0] word;
    logic [7:0]    csum;
    logic          accept, cnt_ok, last;

    assign bs.byte_ready = (state == COUNT) || (state == B0) || (state == B1) ||
                           (state == B2) || (state == CHECK);
    assign accept   = bs.byte_valid && bs.byte_ready;
    assign cnt_ok   = (bs.byte_data[7:6] == 2'b00) && (bs.byte_data[5:0] != 6'd0) &&
                      ({26'd0, bs.byte_data[5:0]} <= DEPTH);
    // Counter is one bit wider than the address so N == DEPTH ends without wrapping.
    assign last     = (cnt + 1'b1) == n;
    assign busy     = (state != IDLE);
    assign cpu_hold = busy;
    assign wr_addr  = cnt[AW-1:0];
    assign wr_data  = word;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE:   if (start) state_n = COUNT;
            COUNT:  if (accept) state_n = cnt_ok ? B0 : FINISH;
            B0:     if (accept) state_n = B1;
            B1:     if (accept) state_n = B2;
            B2:     if (accept) state_n = WRITE;
            WRITE: begin
                wr_en   = 1'b1;
                state_n = last ? CHECK : B0;
            end
            CHECK:  if (accept) state_n = FINISH;
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            n     <= '0;
            word  <= '0;
            csum  <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    error <= 1'b0;
                    csum  <= '0;
                    cnt   <= '0;
                end
                COUNT: if (accept) begin
                    if (cnt_ok) begin
                        n    <= bs.byte_data[AW:0];
                        csum <= csum ^ bs.byte_data;
                    end else begin
                        error <= 1'b1;
                    end
                end
                B0, B1, B2: if (accept) begin
                    // Three shifts leave B0[2:0] in the top bits; the rest of B0 falls off.
                    word <= {word[IW-9:0], bs.byte_data};
                    csum <= csum ^ bs.byte_data;
                end
                WRITE: cnt <= cnt + 1'b1;
                CHECK: if (accept && (bs.byte_data != csum)) error <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed sessions, error paths, full depth, mid-load reset.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        wr_en, cpu_hold, busy, done, error;
    logic [4:0]  wr_addr;
    logic [18:0] wr_data;

    imem_loader_if bs();

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .bs(bs),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int rdy_bad = 0;
    int ncyc = 0;
    int t_rise = 0;
    int t_fall = 0;
    logic err_at_done = 1'b0;
    logic busy_q = 1'b0;
    logic [4:0]  wa[$];
    logic [18:0] wd[$];
    logic [7:0]  stream[$];
    logic [18:0] exp_w[$];

    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            if (bs.byte_ready) rdy_bad++;
        end
        if (done) begin
            done_cnt++;
            err_at_done = error;
        end
        if (busy && !busy_q) t_rise = ncyc;
        if (!busy && busy_q) t_fall = ncyc;
        busy_q = busy;
        ncyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            @(negedge clk);
            bs.byte_valid = 1'b0;
        end
        @(negedge clk);
        bs.byte_data  = b;
        bs.byte_valid = 1'b1;
        t = 0;
        while (!bs.byte_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $error("FAIL ready_timeout observed=%0d expected=<200", t);
        end
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int t;
        @(negedge clk);
        bs.byte_valid = 1'b0;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            failures++;
            $error("FAIL busy_timeout observed=%0d expected=<2000", t);
        end
        @(negedge clk);
    endtask

    task automatic session(input bit gap, input bit chk_clear);
        wa.delete();
        wd.delete();
        pulse_start();
        if (chk_clear) chk("error_cleared_on_start", error, 0);
        foreach (stream[i]) send(stream[i], gap);
        wait_idle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},    bs.byte_ready, 0);
        chk({tag, "_wr_en"},    wr_en, 0);
        chk({tag, "_wr_addr"},  wr_addr, 0);
        chk({tag, "_wr_data"},  wr_data, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_done"},     done, 0);
        chk({tag, "_error"},    error, 0);
    endtask

    initial begin
        int d0;
        logic [7:0] cs, b0, b1, b2;
        logic [7:0] bad_counts[3];

        bs.byte_data  = 8'h00;
        bs.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // single word
        d0 = done_cnt;
        stream = '{8'h01, 8'h05, 8'h88, 8'h00, 8'h8C};
        session(1'b0, 1'b0);
        chk("single_nwrites", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("single_addr", wa[0], 0);
            chk("single_data", wd[0], 19'h58800);
        end
        chk("single_done", done_cnt - d0, 1);
        chk("single_err", err_at_done, 0);
        chk("single_cpu_hold_low", cpu_hold, 0);

        // two words, valid toggling
        d0 = done_cnt;
        stream = '{8'h02, 8'h05, 8'h88, 8'h00, 8'h05, 8'h10, 8'h01, 8'h9B};
        session(1'b1, 1'b0);
        chk("two_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("two_addr0", wa[0], 0);
            chk("two_data0", wd[0], 19'h58800);
            chk("two_addr1", wa[1], 1);
            chk("two_data1", wd[1], 19'h51001);
        end
        chk("two_done", done_cnt - d0, 1);
        chk("two_err", err_at_done, 0);
        chk("ready_low_in_write", rdy_bad, 0);

        // bad checksum, then a good session must clear error on start
        d0 = done_cnt;
        stream = '{8'h01, 8'h05, 8'h88, 8'h00, 8'h8D};
        session(1'b0, 1'b0);
        chk("badcs_nwrites", wa.size(), 1);
        chk("badcs_done", done_cnt - d0, 1);
        chk("badcs_err_at_done", err_at_done, 1);
        chk("badcs_err_sticky", error, 1);
        stream = '{8'h01, 8'h05, 8'h88, 8'h00, 8'h8C};
        session(1'b0, 1'b1);
        chk("after_badcs_err", err_at_done, 0);

        // illegal counts
        bad_counts = '{8'h00, 8'h21, 8'h41};
        foreach (bad_counts[k]) begin
            d0 = done_cnt;
            stream = '{bad_counts[k]};
            session(1'b0, 1'b0);
            chk($sformatf("badcnt_%0h_nwrites", bad_counts[k]), wa.size(), 0);
            chk($sformatf("badcnt_%0h_done", bad_counts[k]), done_cnt - d0, 1);
            chk($sformatf("badcnt_%0h_err", bad_counts[k]), err_at_done, 1);
        end

        // full depth, best case
        d0 = done_cnt;
        stream = '{8'h20};
        exp_w.delete();
        cs = 8'h20;
        for (int i = 0; i < 32; i++) begin
            b0 = 8'(i * 9);
            b1 = 8'(8'h40 + i);
            b2 = ~8'(i);
            stream.push_back(b0);
            stream.push_back(b1);
            stream.push_back(b2);
            cs = cs ^ b0 ^ b1 ^ b2;
            exp_w.push_back({b0[2:0], b1, b2});
        end
        stream.push_back(cs);
        session(1'b0, 1'b0);
        chk("full_nwrites", wa.size(), 32);
        if (wa.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                chk($sformatf("full_addr%0d", i), wa[i], i);
                chk($sformatf("full_data%0d", i), wd[i], exp_w[i]);
            end
        end
        chk("full_done", done_cnt - d0, 1);
        chk("full_err", err_at_done, 0);
        chk("full_cycles", t_fall - t_rise, 131);

        // reset after the second word's B1 byte
        d0 = done_cnt;
        wa.delete();
        wd.delete();
        pulse_start();
        stream = '{8'h02, 8'h05, 8'h88, 8'h00, 8'h05, 8'h10};
        foreach (stream[i]) send(stream[i], 1'b0);
        @(negedge clk);
        bs.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_partial_writes", wa.size(), 1);

        d0 = done_cnt;
        stream = '{8'h02, 8'h05, 8'h88, 8'h00, 8'h05, 8'h10, 8'h01, 8'h9B};
        session(1'b0, 1'b0);
        chk("post_rst_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("post_rst_addr1", wa[1], 1);
            chk("post_rst_data1", wd[1], 19'h51001);
        end
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_err", err_at_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
